// File: rtl/bus_hub_n.sv
// rtl/bus_hub_n.sv - N-device bus hub with base/mask decode, error response and timeout watchdog
module bus_hub_n #(
    parameter int                  N_DEV          = 2,
    parameter logic [N_DEV*32-1:0] BASE_ADDRS     = {32'h1000_0000, 32'h0000_0000},
    parameter logic [N_DEV*32-1:0] ADDR_MASKS     = {32'hFFFF_0000, 32'hFFFF_0000},
    parameter int unsigned         TIMEOUT_CYCLES = 255,
    parameter logic [31:0]         ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           host_address,
    input  logic [31:0]           host_data_write,
    input  logic [3:0]            host_write_mask,
    input  logic                  host_ren,
    input  logic                  host_wen,
    output logic [31:0]           host_data_read,
    output logic                  host_ready,
    output logic                  host_error,
    output logic [N_DEV*32-1:0]   device_address,
    output logic [N_DEV*32-1:0]   device_data_write,
    output logic [N_DEV*4-1:0]    device_write_mask,
    output logic [N_DEV-1:0]      device_ren,
    output logic [N_DEV-1:0]      device_wen,
    input  logic [N_DEV-1:0]      device_ready,
    input  logic [N_DEV*32-1:0]   device_data_read,
    output logic [N_DEV-1:0]      device_active
);

    localparam int SEL_W = (N_DEV > 1) ? $clog2(N_DEV) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state, state_n;

    logic [31:0]      addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0]       wmask_q, wmask_d;
    logic             wr_q, wr_d, err_q, err_d;
    logic [SEL_W-1:0] sel_q, sel_d, hit_idx;
    logic             hit, sel_ready, timeout_hit;
    logic [31:0]      sel_rdata;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_DEV-1:0] ren_q, wen_q, active_q, ren_d, wen_d, active_d;
    logic             ready_q, error_q, ready_d, error_d;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = N_DEV - 1; i >= 0; i--) begin
            if ((host_address & ADDR_MASKS[32*i +: 32]) ==
                (BASE_ADDRS[32*i +: 32] & ADDR_MASKS[32*i +: 32])) begin
                hit     = 1'b1;
                hit_idx = SEL_W'(i);
            end
        end
    end

    assign sel_ready   = device_ready[sel_q];
    assign sel_rdata   = device_data_read[32*sel_q +: 32];
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        wr_d    = wr_q;
        sel_d   = sel_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        case (state)
            IDLE: begin
                if (host_ren || host_wen) begin
                    addr_d  = host_address;
                    wdata_d = host_data_write;
                    wmask_d = host_write_mask;
                    wr_d    = host_wen;
                    sel_d   = hit_idx;
                    cnt_d   = '0;
                    err_d   = !hit;
                    rdata_d = hit ? 32'h0 : ERR_RDATA;
                    state_n = hit ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A ready on the limit cycle still completes normally.
                if (sel_ready) begin
                    rdata_d = wr_q ? 32'h0 : sel_rdata;
                    err_d   = 1'b0;
                    state_n = RESP;
                end else if (timeout_hit) begin
                    rdata_d = ERR_RDATA;
                    err_d   = 1'b1;
                    state_n = RESP;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are computed from next-state values and registered below.
    always_comb begin
        ren_d    = '0;
        wen_d    = '0;
        active_d = '0;
        if (state_n == ACCESS) begin
            active_d[sel_d] = 1'b1;
            if (wr_d) wen_d[sel_d] = 1'b1;
            else      ren_d[sel_d] = 1'b1;
        end
        ready_d = (state_n == RESP);
        error_d = (state_n == RESP) && err_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            wmask_q  <= '0;
            wr_q     <= 1'b0;
            sel_q    <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            cnt_q    <= '0;
            ren_q    <= '0;
            wen_q    <= '0;
            active_q <= '0;
            ready_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wmask_q  <= wmask_d;
            wr_q     <= wr_d;
            sel_q    <= sel_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
            ren_q    <= ren_d;
            wen_q    <= wen_d;
            active_q <= active_d;
            ready_q  <= ready_d;
            error_q  <= error_d;
        end
    end

    assign host_data_read    = rdata_q;
    assign host_ready        = ready_q;
    assign host_error        = error_q;
    assign device_address    = {N_DEV{addr_q}};
    assign device_data_write = {N_DEV{wdata_q}};
    assign device_write_mask = {N_DEV{wmask_q}};
    assign device_ren        = ren_q;
    assign device_wen        = wen_q;
    assign device_active     = active_q;

endmodule
